// File: rtl/probe_capture_if.sv
// Read-back port of the probe capture core: host issues index, core returns sample.
// Latency: rd_data_o/rd_valid_o follow rd_en_i by one clock.
// No backpressure: every accepted request produces exactly one valid beat.
interface probe_capture_if #(
  parameter int WIDTH  = 30,
  parameter int ADDR_W = 10
);

  logic              rd_en_i;
  logic [ADDR_W-1:0] rd_addr_i;
  logic [WIDTH-1:0]  rd_data_o;
  logic              rd_valid_o;

  // Host / UART reader side
  modport master (
    output rd_en_i,
    output rd_addr_i,
    input  rd_data_o,
    input  rd_valid_o
  );

  // Capture core side
  modport slave (
    input  rd_en_i,
    input  rd_addr_i,
    output rd_data_o,
    output rd_valid_o
  );

endinterface

// File: rtl/probe_capture.sv
// Logic-analyzer capture core: circular sample RAM with pre-trigger depth and mask/value trigger.
// Latency: a sample is stored on its sample_en_i cycle; reads return one clock after rd_en_i.
// No backpressure: samples are never stalled, reads are accepted every cycle while DONE.
module probe_capture #(
  parameter int WIDTH  = 30,
  parameter int DEPTH  = 1024,
  // Derived from DEPTH; leave at its default.
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [WIDTH-1:0]  data_i,
  input  logic              sample_en_i,
  input  logic              arm_i,
  input  logic              abort_i,
  input  logic              trig_force_i,
  input  logic [WIDTH-1:0]  trig_mask_i,
  input  logic [WIDTH-1:0]  trig_value_i,
  input  logic              trig_edge_i,
  input  logic [ADDR_W-1:0] pre_trig_i,
  probe_capture_if.slave    rd_if,
  output logic [2:0]        state_o,
  output logic [ADDR_W-1:0] trig_addr_o,
  output logic              done_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PREFILL = 3'd1,
    S_WAIT    = 3'd2,
    S_POST    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  // Capture control state
  state_t            state_q,     state_d;
  logic [ADDR_W-1:0] wr_ptr_q,    wr_ptr_d;
  logic [ADDR_W-1:0] cnt_q,       cnt_d;
  logic              prev_hit_q,  prev_hit_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
  logic              done_q,      done_d;
  logic              rd_valid_q,  rd_valid_d;

  // Trigger configuration, frozen at arm time
  logic [WIDTH-1:0]  mask_q,  mask_d;
  logic [WIDTH-1:0]  value_q, value_d;
  logic              edge_q,  edge_d;
  logic [ADDR_W-1:0] pre_q,   pre_d;

  // Sample storage; contents are never reset
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [WIDTH-1:0]  rd_data_q;

  logic              wr_en;
  logic              rd_fire;
  logic              hit;
  logic              trig;
  logic [ADDR_W-1:0] cnt_inc;
  logic [ADDR_W-1:0] post_len;
  logic [ADDR_W-1:0] rd_phys;

  // Trigger match on the live probe bus against the latched config
  always_comb begin
    hit  = (((data_i ^ value_q) & mask_q) == '0);
    trig = (edge_q ? (hit & ~prev_hit_q) : hit) | trig_force_i;
  end

  // Post-trigger length is DEPTH-1-pre, which in ADDR_W bits is simply ~pre.
  // Read index is rebased so logical 0 is the oldest sample in the frozen buffer.
  assign cnt_inc  = cnt_q + ADDR_ONE;
  assign post_len = ~pre_q;
  assign rd_phys  = trig_addr_q - pre_q + rd_if.rd_addr_i;

  // Next-state logic: abort beats arm, arm beats normal sampling and reads
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    cnt_d       = cnt_q;
    prev_hit_d  = prev_hit_q;
    trig_addr_d = trig_addr_q;
    mask_d      = mask_q;
    value_d     = value_q;
    edge_d      = edge_q;
    pre_d       = pre_q;
    wr_en       = 1'b0;
    rd_fire     = 1'b0;

    if (abort_i) begin
      state_d = S_IDLE;
    end else if (arm_i) begin
      mask_d     = trig_mask_i;
      value_d    = trig_value_i;
      edge_d     = trig_edge_i;
      pre_d      = pre_trig_i;
      wr_ptr_d   = '0;
      cnt_d      = '0;
      prev_hit_d = 1'b0;
      state_d    = (pre_trig_i == '0) ? S_WAIT : S_PREFILL;
    end else begin
      rd_fire = rd_if.rd_en_i && (state_q == S_DONE);
      wr_en   = sample_en_i &&
                ((state_q == S_PREFILL) || (state_q == S_WAIT) || (state_q == S_POST));

      if (wr_en) begin
        wr_ptr_d   = wr_ptr_q + ADDR_ONE;
        prev_hit_d = hit;
        case (state_q)
          S_PREFILL: begin
            // Trigger is ignored until the pre-trigger window is full
            if (cnt_inc == pre_q) begin
              cnt_d   = '0;
              state_d = S_WAIT;
            end else begin
              cnt_d = cnt_inc;
            end
          end
          S_WAIT: begin
            if (trig) begin
              trig_addr_d = wr_ptr_q;
              cnt_d       = '0;
              state_d     = (post_len == '0) ? S_DONE : S_POST;
            end
          end
          S_POST: begin
            if (cnt_inc == post_len) begin
              cnt_d   = '0;
              state_d = S_DONE;
            end else begin
              cnt_d = cnt_inc;
            end
          end
          default: ;
        endcase
      end
    end

    done_d     = (state_d == S_DONE);
    rd_valid_d = rd_fire;
  end

  // Control and config registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      prev_hit_q  <= 1'b0;
      trig_addr_q <= '0;
      done_q      <= 1'b0;
      rd_valid_q  <= 1'b0;
      mask_q      <= '0;
      value_q     <= '0;
      edge_q      <= 1'b0;
      pre_q       <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      prev_hit_q  <= prev_hit_d;
      trig_addr_q <= trig_addr_d;
      done_q      <= done_d;
      rd_valid_q  <= rd_valid_d;
      mask_q      <= mask_d;
      value_q     <= value_d;
      edge_q      <= edge_d;
      pre_q       <= pre_d;
    end
  end

  // RAM write port: kept free of reset so it maps onto block RAM
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= data_i;
    end
  end

  // RAM read port with registered output; output register clears on reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_data_q <= '0;
    end else if (rd_fire) begin
      rd_data_q <= mem[rd_phys];
    end
  end

  assign rd_if.rd_data_o  = rd_data_q;
  assign rd_if.rd_valid_o = rd_valid_q;
  assign state_o          = state_q;
  assign trig_addr_o      = trig_addr_q;
  assign done_o           = done_q;

endmodule

// File: tb/tb_probe_capture.sv
// Directed bench for probe_capture at WIDTH=8, DEPTH=16.
// Table of per-cycle vectors plus hand sequences for ramp capture, sample gaps and reset.
// Outputs are sampled 1 ns after each rising edge.
module tb_probe_capture;

  localparam int W  = 8;
  localparam int D  = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          sen, arm, abort, force_t, edge_m;
  logic [W-1:0]  data, mask, value;
  logic [AW-1:0] pre;
  logic [2:0]    state;
  logic [AW-1:0] ta;
  logic          done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  probe_capture_if #(.WIDTH(W), .ADDR_W(AW)) rif ();

  probe_capture #(.WIDTH(W), .DEPTH(D)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .data_i       (data),
    .sample_en_i  (sen),
    .arm_i        (arm),
    .abort_i      (abort),
    .trig_force_i (force_t),
    .trig_mask_i  (mask),
    .trig_value_i (value),
    .trig_edge_i  (edge_m),
    .pre_trig_i   (pre),
    .rd_if        (rif),
    .state_o      (state),
    .trig_addr_o  (ta),
    .done_o       (done)
  );

  typedef struct {
    string         nm;
    logic          arm, abort, frc, sen, ren, edg;
    logic [W-1:0]  d, msk, val;
    logic [AW-1:0] pre, ra;
    logic [2:0]    es;
    logic          ed, erv, crd, cta;
    logic [W-1:0]  erd;
    logic [AW-1:0] eta;
  } vec_t;

  vec_t vecs[$];

  logic [W-1:0]  c_msk, c_val;
  logic          c_edg;
  logic [AW-1:0] c_pre;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [W-1:0] m, input logic [W-1:0] v, input logic e, input logic [AW-1:0] p);
    c_msk = m; c_val = v; c_edg = e; c_pre = p;
  endtask

  task automatic add(input string nm, input logic a, input logic ab, input logic fr, input logic s,
                     input logic [W-1:0] d, input logic re, input logic [AW-1:0] ra,
                     input logic [2:0] es, input logic erv, input logic crd, input logic [W-1:0] erd);
    vec_t v;
    v.nm = nm; v.arm = a; v.abort = ab; v.frc = fr; v.sen = s; v.d = d;
    v.ren = re; v.ra = ra; v.es = es; v.ed = (es == 3'd4); v.erv = erv;
    v.crd = crd; v.erd = erd; v.cta = 1'b0; v.eta = '0;
    v.msk = c_msk; v.val = c_val; v.edg = c_edg; v.pre = c_pre;
    vecs.push_back(v);
  endtask

  task automatic samp(input string nm, input logic [W-1:0] d, input logic [2:0] es);
    add(nm, 1'b0, 1'b0, 1'b0, 1'b1, d, 1'b0, 4'd0, es, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic rd(input string nm, input logic [AW-1:0] ra, input logic [W-1:0] erd);
    add(nm, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, ra, 3'd4, 1'b1, 1'b1, erd);
  endtask

  task automatic mark_ta(input logic [AW-1:0] eta);
    vecs[vecs.size()-1].cta = 1'b1;
    vecs[vecs.size()-1].eta = eta;
  endtask

  task automatic idle_inputs();
    arm = 1'b0; abort = 1'b0; force_t = 1'b0; sen = 1'b0; data = '0;
    rif.rd_en_i = 1'b0; rif.rd_addr_i = '0;
  endtask

  initial begin
    int n;
    // ---------------- vector table ----------------
    // Edge mode: level held through prefill must not fire; fires on return to 0x55
    cfg(8'hFF, 8'h55, 1'b1, 4'd4);
    add("s2_arm", 1'b1, 1'b0, 1'b0, 1'b0, 8'h55, 1'b0, 4'd0, 3'd1, 1'b0, 1'b0, 8'h00);
    for (int k = 0; k < 4; k++) samp($sformatf("s2_pre%0d", k), 8'h55, (k < 3) ? 3'd1 : 3'd2);
    for (int k = 0; k < 3; k++) samp($sformatf("s2_hold%0d", k), 8'h55, 3'd2);
    samp("s2_drop", 8'h00, 3'd2);
    samp("s2_rise", 8'h55, 3'd3);
    for (int j = 0; j < 11; j++) samp($sformatf("s2_post%0d", j), 8'(8'h10 + j), (j < 10) ? 3'd3 : 3'd4);
    mark_ta(4'd8);
    rd("s2_rd4", 4'd4, 8'h55);
    rd("s2_rd3", 4'd3, 8'h00);
    rd("s2_rd2", 4'd2, 8'h55);
    rd("s2_rd5", 4'd5, 8'h10);
    rd("s2_rd15", 4'd15, 8'h1A);
    add("s2_hold_rd", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 3'd4, 1'b0, 1'b1, 8'h1A);
    samp("s2_done_wr", 8'h99, 3'd4);
    rd("s2_rd0", 4'd0, 8'h55);
    // Abort during POST
    cfg(8'hFF, 8'h55, 1'b0, 4'd4);
    add("s4_arm", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 3'd1, 1'b0, 1'b0, 8'h00);
    for (int k = 0; k < 4; k++) samp($sformatf("s4_pre%0d", k), 8'h00, (k < 3) ? 3'd1 : 3'd2);
    samp("s4_trig", 8'h55, 3'd3);
    samp("s4_post", 8'h01, 3'd3);
    add("s4_abort", 1'b0, 1'b1, 1'b0, 1'b1, 8'h55, 1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 8'h00);
    add("s4_rd_idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 4'd0, 3'd0, 1'b0, 1'b1, 8'h55);
    // arm+abort collisions, pre=0, restart in WAIT_TRIG, forced trigger
    add("s5_armab_idle", 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 8'h00);
    add("s5_arm", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 3'd1, 1'b0, 1'b0, 8'h00);
    add("s5_armab_pre", 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 8'h00);
    cfg(8'hFF, 8'h55, 1'b0, 4'd0);
    add("s5_arm_p0", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 3'd2, 1'b0, 1'b0, 8'h00);
    for (int k = 0; k < 3; k++) samp($sformatf("s5_wait%0d", k), 8'h00, 3'd2);
    add("s5_rearm", 1'b1, 1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 4'd0, 3'd2, 1'b0, 1'b0, 8'h00);
    samp("s5_w0", 8'h00, 3'd2);
    add("s5_force", 1'b0, 1'b0, 1'b1, 1'b1, 8'h77, 1'b0, 4'd0, 3'd3, 1'b0, 1'b0, 8'h00);
    for (int j = 0; j < 15; j++) samp($sformatf("s5_post%0d", j), 8'(8'h20 + j), (j < 14) ? 3'd3 : 3'd4);
    mark_ta(4'd1);
    rd("s5_rd0", 4'd0, 8'h77);
    rd("s5_rd1", 4'd1, 8'h20);
    rd("s5_rd15", 4'd15, 8'h2E);
    // pre=15: no post phase, trigger at logical 15; match during prefill ignored
    cfg(8'hFF, 8'h55, 1'b0, 4'd15);
    add("s3_arm", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 3'd1, 1'b0, 1'b0, 8'h00);
    for (int k = 0; k < 15; k++)
      samp($sformatf("s3_pre%0d", k), (k == 5) ? 8'h55 : 8'(8'h30 + k), (k < 14) ? 3'd1 : 3'd2);
    samp("s3_trig", 8'h55, 3'd4);
    mark_ta(4'd15);
    rd("s3_rd15", 4'd15, 8'h55);
    rd("s3_rd0", 4'd0, 8'h30);
    rd("s3_rd5", 4'd5, 8'h55);
    rd("s3_rd14", 4'd14, 8'h3E);

    // ---------------- reset ----------------
    rst = 1'b1; idle_inputs();
    mask = '0; value = '0; edge_m = 1'b0; pre = '0;
    tick(); tick();
    check("rst_state", state, 3'd0);
    check("rst_done", done, 1'b0);
    check("rst_rv", rif.rd_valid_o, 1'b0);
    check("rst_rd", rif.rd_data_o, 8'h00);
    check("rst_ta", ta, 4'd0);
    rst = 1'b0;
    tick();

    // ---------------- ramp capture, level mode ----------------
    mask = 8'hFF; value = 8'h55; edge_m = 1'b0; pre = 4'd4;
    arm = 1'b1; tick(); arm = 1'b0;
    check("s1_arm", state, 3'd1);
    mask = 8'h00; pre = 4'd9;   // must be ignored mid-capture
    for (int k = 0; k <= 96; k++) begin
      sen = 1'b1; data = 8'(k);
      tick();
      check($sformatf("s1_st%0d", k), state, (k < 3) ? 3'd1 : (k < 85) ? 3'd2 : (k < 96) ? 3'd3 : 3'd4);
    end
    sen = 1'b0;
    check("s1_done", done, 1'b1);
    check("s1_ta", ta, 4'd5);
    for (int i = 0; i < 16; i++) begin
      rif.rd_en_i = 1'b1; rif.rd_addr_i = 4'(i);
      tick();
      check($sformatf("s1_rv%0d", i), rif.rd_valid_o, 1'b1);
      check($sformatf("s1_rd%0d", i), rif.rd_data_o, 8'(81 + i));
    end
    rif.rd_en_i = 1'b0;
    tick();
    check("s1_rv_off", rif.rd_valid_o, 1'b0);

    // ---------------- table ----------------
    foreach (vecs[i]) begin
      arm = vecs[i].arm; abort = vecs[i].abort; force_t = vecs[i].frc;
      sen = vecs[i].sen; data = vecs[i].d; mask = vecs[i].msk; value = vecs[i].val;
      edge_m = vecs[i].edg; pre = vecs[i].pre;
      rif.rd_en_i = vecs[i].ren; rif.rd_addr_i = vecs[i].ra;
      tick();
      check({vecs[i].nm, ".state"}, state, vecs[i].es);
      check({vecs[i].nm, ".done"}, done, vecs[i].ed);
      check({vecs[i].nm, ".rv"}, rif.rd_valid_o, vecs[i].erv);
      if (vecs[i].crd) check({vecs[i].nm, ".rd"}, rif.rd_data_o, vecs[i].erd);
      if (vecs[i].cta) check({vecs[i].nm, ".ta"}, ta, vecs[i].eta);
    end
    idle_inputs();

    // ---------------- 1-in-3 sample gaps, mask=0 ----------------
    mask = 8'h00; value = 8'hA5; edge_m = 1'b0; pre = 4'd2;
    arm = 1'b1; tick(); arm = 1'b0;
    n = 0;
    for (int c = 0; c < 100; c++) begin
      sen = ((c % 3) == 0);
      data = sen ? 8'(8'h40 + n) : 8'hEE;
      tick();
      if (sen) n++;
      check($sformatf("s6_st%0d", c), state,
            (n < 2) ? 3'd1 : (n == 2) ? 3'd2 : (n < 16) ? 3'd3 : 3'd4);
      if (n == 16) break;
    end
    sen = 1'b0;
    check("s6_ta", ta, 4'd2);
    for (int i = 0; i < 16; i++) begin
      rif.rd_en_i = 1'b1; rif.rd_addr_i = 4'(i);
      tick();
      check($sformatf("s6_rd%0d", i), rif.rd_data_o, 8'(8'h40 + i));
    end
    rif.rd_en_i = 1'b0;

    // Re-arm and reset in the middle of POST
    arm = 1'b1; tick(); arm = 1'b0;
    n = 0;
    for (int c = 0; c < 30 && n < 5; c++) begin
      sen = ((c % 3) == 0);
      data = 8'h11;
      tick();
      if (sen) n++;
    end
    sen = 1'b0;
    check("s6_in_post", state, 3'd3);
    rst = 1'b1; tick(); rst = 1'b0;
    check("s6_rst_state", state, 3'd0);
    check("s6_rst_done", done, 1'b0);
    check("s6_rst_rv", rif.rd_valid_o, 1'b0);
    check("s6_rst_rd", rif.rd_data_o, 8'h00);
    check("s6_rst_ta", ta, 4'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
